// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   cnt_w(depth) : width of a counter that holds 0..depth
//   err_e        : error classification used when reporting adapter faults
package fifo_stream_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_OVF   = 2'd1,
    ERR_UNEXP = 2'd2
  } err_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Circular register buffer (skid buffer) with push/pop.
//   clk, rst      : clock, synchronous active-high reset
//   push_i, din_i : write din_i at the write pointer
//   pop_i         : retire the head entry
//   cnt_o         : occupied entries
//   full_o/empty_o: occupancy flags
//   head_o        : entry at the read pointer (registered storage)
// DEPTH need not be a power of two; pointers wrap explicitly.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DW    = 18,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [DW-1:0]             din_i,
  input  logic                      pop_i,
  output logic [cnt_w(DEPTH)-1:0]   cnt_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [DW-1:0]             head_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     pop_ok, wr_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // When full, a same-cycle pop frees the head slot, which is exactly where
  // wr_ptr points, so the write may proceed.
  assign pop_ok = pop_i & ~empty_o;
  assign wr_en  = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en)  wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (wr_en && !pop_ok)      cnt_d = cnt_q + CW'(1);
    else if (!wr_en && pop_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Converts the fixed-latency read port of the sync FIFO into a valid/ready
// stream master. Reads are issued only against free skid credits, so every
// returning word has a slot and m_ready may drop in any cycle.
//   clk, rst         : clock, synchronous active-high reset
//   fifo_empty       : registered empty flag of the upstream FIFO
//   fifo_ren         : read request to the FIFO
//   fifo_dout_valid  : read return strobe (RD_LAT cycles after fifo_ren)
//   fifo_dout        : read return data
//   m_valid/m_ready/m_data : stream master
//   skid_cnt         : occupied skid entries
//   ovf_err          : sticky, return arrived with skid full and no pop
//   unexp_err        : sticky, return arrived with no read outstanding
module fifo_rd_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter int DW         = 18,
  parameter int RD_LAT     = 3,
  parameter int SKID_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fifo_empty,
  output logic                            fifo_ren,
  input  logic                            fifo_dout_valid,
  input  logic [DW-1:0]                   fifo_dout,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DW-1:0]                   m_data,
  output logic [cnt_w(SKID_DEPTH)-1:0]    skid_cnt,
  output logic                            ovf_err,
  output logic                            unexp_err
);

  localparam int CW = cnt_w(SKID_DEPTH);

  if (RD_LAT < 1 || SKID_DEPTH < 2) begin : g_param_chk
    $error("fifo_rd_stream_adapter: RD_LAT must be >= 1 and SKID_DEPTH >= 2");
  end

  logic          pop, push, sk_full, sk_empty;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          ovf_q, ovf_d, unexp_q, unexp_d;
  logic [CW+1:0] committed;
  logic          inflight_nz;

  stream_skid_buf #(
    .DW    (DW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (fifo_dout),
    .pop_i   (pop),
    .cnt_o   (skid_cnt),
    .full_o  (sk_full),
    .empty_o (sk_empty),
    .head_o  (m_data)
  );

  assign m_valid     = ~sk_empty;
  assign pop         = m_valid & m_ready;
  assign push        = fifo_dout_valid;
  assign inflight_nz = (inflight_q != '0);

  // Slots already promised: outstanding reads plus held words, less the word
  // leaving this cycle. pop implies skid_cnt >= 1, so this cannot underflow.
  assign committed = (CW+2)'(inflight_q) + (CW+2)'(skid_cnt) - (CW+2)'(pop);
  assign fifo_ren  = ~rst & ~fifo_empty & (committed < (CW+2)'(SKID_DEPTH));

  always_comb begin
    inflight_d = inflight_q;
    // An unexpected return never decrements below zero.
    case ({fifo_ren, push & inflight_nz})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    ovf_d   = ovf_q   | (push & sk_full & ~pop);
    unexp_d = unexp_q | (push & ~inflight_nz);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      ovf_q      <= 1'b0;
      unexp_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
      unexp_q    <= unexp_d;
    end
  end

  assign ovf_err   = ovf_q;
  assign unexp_err = unexp_q;

endmodule
